vme_cycle_seq: RTL

Parametrised VME master cycle sequencer for OTMB simulation and bring-up benches: it replaces free-running clock toggles and fixed initial blocks with a scripted, handshaken VME bus stimulus. It queues host commands in a FIFO and executes them as A24/D16 single cycles toward the FPGA's VME slave port. It waits for DTACK with a per-cycle timeout and returns read data and status per cycle.

---
 rtl/vme_cycle_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/vme_cycle_seq.sv
// vme_cycle_seq: FIFO-fed A24/D16 VME master single-cycle sequencer.
// Define VME_SEQ_READ_CHECK_EN to compare read data against cmd_wdata.
module vme_cycle_seq #(
  parameter int         ADR_W     = 23,
  parameter int         DATA_W    = 16,
  parameter int         DEPTH     = 16,
  parameter int         SETUP_CYC = 2,
  parameter int         TIMEOUT   = 255,
  parameter logic [5:0] AM        = 6'h39
) (
  input  logic                     clock,
  input  logic                     _reset,
  input  logic                     cmd_we,
  input  logic                     cmd_rw,
  input  logic [ADR_W-1:0]         cmd_adr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     cmd_full,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic [ADR_W-1:0]         vme_a,
  output logic [5:0]               vme_am,
  output logic                     _vme_as,
  output logic                     _vme_ds,
  output logic                     _vme_write,
  output logic [DATA_W-1:0]        vme_d_out,
  output logic                     vme_d_oe,
  input  logic [DATA_W-1:0]        vme_d_in,
  input  logic                     _vme_dtack,
  output logic                     busy,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     rsp_mismatch
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 1 + ADR_W + DATA_W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [15:0] SET_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, RELEASE, GAP
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push, pop;
  logic              h_rw;
  logic [ADR_W-1:0]  h_adr;
  logic [DATA_W-1:0] h_wd;

  logic              dtk_m, dtack_s;
  logic [15:0]       cnt;
  logic              cnt_clr, cap, to_err, fire;
  logic              cyc_rw, cyc_err, mis;
  logic [DATA_W-1:0] cyc_rdata;

  assign cmd_full  = (count == FULL);
  assign cmd_count = count;
  assign push      = cmd_we && !cmd_full;
  assign {h_rw, h_adr, h_wd} = mem[rd_ptr];

  assign vme_am  = AM;
  assign _vme_as = (state != STROBE);
  assign _vme_ds = (state != STROBE);
  assign busy    = (state != IDLE) || (count != '0);

  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= {cmd_rw, cmd_adr, cmd_wdata};

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // DTACK is asynchronous to clock
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      dtk_m   <= 1'b0;
      dtack_s <= 1'b0;
    end else begin
      dtk_m   <= ~_vme_dtack;
      dtack_s <= dtk_m;
    end
  end

  always_ff @(posedge clock or negedge _reset)
    if (!_reset) state <= IDLE;
    else         state <= state_n;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    cnt_clr = 1'b0;
    cap     = 1'b0;
    to_err  = 1'b0;
    fire    = 1'b0;
    unique case (state)
      IDLE: if (count != '0) begin
        pop     = 1'b1;
        cnt_clr = 1'b1;
        state_n = SETUP;
      end
      SETUP: if (cnt == SET_LAST) begin
        cnt_clr = 1'b1;
        state_n = STROBE;
      end
      STROBE: if (dtack_s) begin
        cap     = 1'b1;
        cnt_clr = 1'b1;
        state_n = RELEASE;
      end else if (cnt == TO_LAST) begin
        to_err  = 1'b1;
        cnt_clr = 1'b1;
        state_n = RELEASE;
      end
      RELEASE: if (!dtack_s) begin
        fire    = 1'b1;
        state_n = GAP;
      end else if (cnt == TO_LAST) begin
        to_err  = 1'b1;
        fire    = 1'b1;
        state_n = GAP;
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef VME_SEQ_READ_CHECK_EN
  logic [DATA_W-1:0] cyc_exp;

  always_ff @(posedge clock or negedge _reset)
    if (!_reset)  cyc_exp <= '0;
    else if (pop) cyc_exp <= h_wd;

  assign mis = cyc_rw && !(cyc_err || to_err)
            && (cyc_rdata != cyc_exp);

`ifndef SYNTHESIS
  always @(posedge clock)
    if (fire && mis)
      $display("vme_cycle_seq: read compare miss adr=%h got=%h exp=%h",
               vme_a, cyc_rdata, cyc_exp);
`endif
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      cnt          <= '0;
      cyc_rw       <= 1'b0;
      cyc_err      <= 1'b0;
      cyc_rdata    <= '0;
      vme_a        <= '0;
      _vme_write   <= 1'b1;
      vme_d_out    <= '0;
      vme_d_oe     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      rsp_mismatch <= 1'b0;
    end else begin
      rsp_valid <= fire;
      if (cnt_clr)              cnt <= '0;
      else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      if (pop) begin
        cyc_rw     <= h_rw;
        cyc_err    <= 1'b0;
        cyc_rdata  <= '0;
        vme_a      <= h_adr;
        _vme_write <= h_rw;
        vme_d_oe   <= !h_rw;
        vme_d_out  <= h_rw ? '0 : h_wd;
      end
      if (state == STROBE && state_n == RELEASE)
        vme_d_oe <= 1'b0;
      if (cap && cyc_rw) cyc_rdata <= vme_d_in;
      if (to_err)        cyc_err   <= 1'b1;
      if (fire) begin
        vme_a        <= '0;
        _vme_write   <= 1'b1;
        vme_d_out    <= '0;
        rsp_rdata    <= cyc_rdata;
        rsp_err      <= cyc_err || to_err;
        rsp_mismatch <= mis;
      end
    end
  end

endmodule
